// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - two-port (icache/dcache) round-robin arbiter with burst-locked grant onto one L2 request port
//
// Optional feature macro: XENTRY_L2ARB_STATS_EN (grant/contention statistics counters and their ports).
//
// Ports:
//   clk, reset (sync, active-low)
//   ic_req_*   : icache request (address, type, valid) and response (fetched_word, fulfilled)
//   dc_req_*   : dcache request (address, type, valid, word_to_store) and response
//   l2_req_*   : shared L2 request (address, type, valid, word_to_store) and response
//   ic_grant_count, dc_grant_count, contention_cycles : statistics (only with XENTRY_L2ARB_STATS_EN)
module l2_request_arbiter #(
  parameter int XLEN        = 32,
  parameter int STATS_WIDTH = 32,
  parameter int OP_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        ic_req_address,
  input  logic [OP_WIDTH-1:0]    ic_req_type,
  input  logic                   ic_req_valid,
  output logic [XLEN-1:0]        ic_fetched_word,
  output logic                   ic_req_fulfilled,
  input  logic [XLEN-1:0]        dc_req_address,
  input  logic [OP_WIDTH-1:0]    dc_req_type,
  input  logic                   dc_req_valid,
  input  logic [XLEN-1:0]        dc_word_to_store,
  output logic [XLEN-1:0]        dc_fetched_word,
  output logic                   dc_req_fulfilled,
  output logic [XLEN-1:0]        l2_req_address,
  output logic [OP_WIDTH-1:0]    l2_req_type,
  output logic                   l2_req_valid,
  output logic [XLEN-1:0]        l2_word_to_store,
  input  logic [XLEN-1:0]        l2_fetched_word,
  input  logic                   l2_req_fulfilled
`ifdef XENTRY_L2ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] ic_grant_count,
  output logic [STATS_WIDTH-1:0] dc_grant_count,
  output logic [STATS_WIDTH-1:0] contention_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2
  } state_e;

  state_e r_state;
  state_e w_next_state;
  // 1 = dcache was the most recent winner; reset value makes the icache win the first tie
  logic   r_last_dc;
  logic   w_enter_ic;
  logic   w_enter_dc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last_dc <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_enter_ic) begin
        r_last_dc <= 1'b0;
      end else if (w_enter_dc) begin
        r_last_dc <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (ic_req_valid && dc_req_valid) begin
          w_next_state = r_last_dc ? GRANT_IC : GRANT_DC;
        end else if (ic_req_valid) begin
          w_next_state = GRANT_IC;
        end else if (dc_req_valid) begin
          w_next_state = GRANT_DC;
        end
      end
      // Owner keeps the port while it holds valid; on release hand off directly if the other side waits.
      GRANT_IC: begin
        if (!ic_req_valid) begin
          w_next_state = dc_req_valid ? GRANT_DC : IDLE;
        end
      end
      GRANT_DC: begin
        if (!dc_req_valid) begin
          w_next_state = ic_req_valid ? GRANT_IC : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_enter_ic = (w_next_state == GRANT_IC) && (r_state != GRANT_IC);
  assign w_enter_dc = (w_next_state == GRANT_DC) && (r_state != GRANT_DC);

  always_comb begin
    l2_req_address   = '0;
    l2_req_type      = '0;
    l2_req_valid     = 1'b0;
    l2_word_to_store = '0;
    ic_req_fulfilled = 1'b0;
    dc_req_fulfilled = 1'b0;
    case (r_state)
      GRANT_IC: begin
        l2_req_address   = ic_req_address;
        l2_req_type      = ic_req_type;
        l2_req_valid     = ic_req_valid;
        ic_req_fulfilled = l2_req_fulfilled;
      end
      GRANT_DC: begin
        l2_req_address   = dc_req_address;
        l2_req_type      = dc_req_type;
        l2_req_valid     = dc_req_valid;
        l2_word_to_store = dc_word_to_store;
        dc_req_fulfilled = l2_req_fulfilled;
      end
      default: ;
    endcase
    // Reset kills the handshake immediately so an interrupted burst never reports completion.
    if (!reset) begin
      l2_req_valid     = 1'b0;
      ic_req_fulfilled = 1'b0;
      dc_req_fulfilled = 1'b0;
    end
  end

  assign ic_fetched_word = l2_fetched_word;
  assign dc_fetched_word = l2_fetched_word;

`ifdef XENTRY_L2ARB_STATS_EN
  logic [STATS_WIDTH-1:0] r_ic_grant_count;
  logic [STATS_WIDTH-1:0] r_dc_grant_count;
  logic [STATS_WIDTH-1:0] r_contention_cycles;
  logic                   w_contention;

  assign w_contention = ((r_state == GRANT_IC) && dc_req_valid)
                     || ((r_state == GRANT_DC) && ic_req_valid)
                     || ((r_state == IDLE) && ic_req_valid && dc_req_valid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ic_grant_count    <= '0;
      r_dc_grant_count    <= '0;
      r_contention_cycles <= '0;
    end else begin
      if (w_enter_ic && (r_ic_grant_count != '1)) begin
        r_ic_grant_count <= r_ic_grant_count + STATS_WIDTH'(1);
      end
      if (w_enter_dc && (r_dc_grant_count != '1)) begin
        r_dc_grant_count <= r_dc_grant_count + STATS_WIDTH'(1);
      end
      if (w_contention && (r_contention_cycles != '1)) begin
        r_contention_cycles <= r_contention_cycles + STATS_WIDTH'(1);
      end
    end
  end

  assign ic_grant_count    = r_ic_grant_count;
  assign dc_grant_count    = r_dc_grant_count;
  assign contention_cycles = r_contention_cycles;
`endif

endmodule
